// File: rtl/mem_pkg.sv
// Shared memory-request types and helpers for the SRAM initiator and the cache refill path.
package mem_pkg;
  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved size, or an access that is not naturally aligned.
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSV) || ((size == SZ_H) && off[0]) ||
           ((size == SZ_W) && (off != 2'b00));
  endfunction
endpackage

// File: rtl/sram_req_master_if.sv
// Core request/response channel plus the single-port DPI SRAM pins.
interface sram_req_master_if;
  import mem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_wen;
  logic [31:0]        req_addr;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [31:0]        req_wdata;

  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_rdata;
  logic               resp_err;

  logic [31:0]        sram_addr;
  logic [SRAM_DW-1:0] sram_wdata;
  logic [SRAM_MW-1:0] sram_wmask;
  logic               sram_ena;
  logic               sram_wen;
  logic [SRAM_DW-1:0] sram_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output sram_addr, sram_wdata, sram_wmask, sram_ena, sram_wen,
    input  sram_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  sram_addr, sram_wdata, sram_wmask, sram_ena, sram_wen,
    output sram_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/replicated data from offset+size, load extract and extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [31:0] shifted;

  assign shifted = ld_rdata >> {ld_off, 3'b000};

  always_comb begin
    st_mask = 4'h0;
    st_data = st_wdata;
    case (st_size)
      SZ_B: begin
        st_mask = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_mask = 4'b0011 << st_off;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_W:    st_mask = 4'hF;
      default: st_mask = 4'h0;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      SZ_W:    ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end
endmodule

// File: rtl/sram_req_master.sv
// One-outstanding SRAM initiator: one-cycle SRAM strobe, response RD_LAT cycles later (errors: next cycle).
// Response registers hold steady until resp_ready; no new request is taken until the response retires.
module sram_req_master
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  sram_req_master_if.master bus
);
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e      state;
  state_e      state_nxt;
  logic        accept;
  logic        err;
  logic [1:0]  cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        wen_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] ld_data;

  assign err = req_error(bus.req_size, bus.req_addr[1:0]);

  mem_lane_align u_align (
    .st_off      (bus.req_addr[1:0]),
    .st_size     (bus.req_size),
    .st_wdata    (bus.req_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_off      (off_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (bus.sram_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)          state_nxt = err ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 2'd0)     state_nxt = ST_RESP;
      ST_RESP: if (bus.resp_ready)  state_nxt = ST_IDLE;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // Every SRAM pin is forced low outside the single strobe cycle.
  always_comb begin
    bus.req_ready  = (state == ST_IDLE) & ~reset;
    accept         = bus.req_valid & bus.req_ready;
    bus.sram_ena   = accept & ~err;
    bus.sram_wen   = bus.sram_ena & bus.req_wen;
    bus.sram_addr  = bus.sram_ena ? {bus.req_addr[31:2], 2'b00} : 32'h0;
    bus.sram_wdata = bus.sram_wen ? st_data : 32'h0;
    bus.sram_wmask = bus.sram_wen ? {4'h0, st_mask} : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      cnt          <= 2'd0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wen_q        <= 1'b0;
    end else begin
      resp_valid_q <= (state_nxt == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            off_q  <= bus.req_addr[1:0];
            size_q <= bus.req_size;
            uns_q  <= bus.req_unsigned;
            wen_q  <= bus.req_wen;
            cnt    <= CNT_INIT;
            if (err) begin
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
            end else begin
              resp_err_q   <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 2'd0) resp_rdata_q <= wen_q ? 32'h0 : ld_data;
          else             cnt          <= cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_sram_req_master.sv
// Drives two instances (RD_LAT 1 and 3) against a byte-array SRAM and a byte-level reference memory.
module tb_sram_req_master;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        rq_valid [2];
  logic        rs_ready [2];
  logic        rq_wen, rq_uns;
  logic [31:0] rq_addr, rq_wdata;
  logic [1:0]  rq_size;

  logic        req_ready [2];
  logic        resp_valid [2];
  logic        resp_err [2];
  logic [31:0] resp_rdata [2];
  logic        s_ena [2];
  logic        s_wen [2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [7:0]  s_wmask [2];
  logic [31:0] s_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_req_master_if bus ();
    sram_req_master #(.RD_LAT(g == 0 ? 1 : 3)) u_dut (.clock(clock), .reset(reset), .bus(bus));
    assign bus.req_valid    = rq_valid[g];
    assign bus.req_wen      = rq_wen;
    assign bus.req_addr     = rq_addr;
    assign bus.req_size     = rq_size;
    assign bus.req_unsigned = rq_uns;
    assign bus.req_wdata    = rq_wdata;
    assign bus.resp_ready   = rs_ready[g];
    assign bus.sram_rdata   = s_rdata[g];
    assign req_ready[g]     = bus.req_ready;
    assign resp_valid[g]    = bus.resp_valid;
    assign resp_err[g]      = bus.resp_err;
    assign resp_rdata[g]    = bus.resp_rdata;
    assign s_ena[g]         = bus.sram_ena;
    assign s_wen[g]         = bus.sram_wen;
    assign s_addr[g]        = bus.sram_addr;
    assign s_wdata[g]       = bus.sram_wdata;
    assign s_wmask[g]       = bus.sram_wmask;
  end

  function automatic int rdl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // SRAM model: data for an access appears RD_LAT-1 cycles after the strobe edge, junk before that.
  logic [7:0]  mem [2][64];
  logic [7:0]  rm  [2][64];
  int          k [2]       = '{100, 100};
  int          ena_cnt [2] = '{0, 0};
  logic [5:0]  ra [2]      = '{6'd0, 6'd0};
  logic [31:0] junk [2]    = '{32'h0, 32'h0};

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      junk[d] <= $urandom;
      if (k[d] < 100) k[d] <= k[d] + 1;
      if (s_ena[d]) begin
        ra[d]      <= s_addr[d][5:0];
        k[d]       <= 0;
        ena_cnt[d] <= ena_cnt[d] + 1;
        if (s_wen[d])
          for (int i = 0; i < 4; i++)
            if (s_wmask[d][i]) mem[d][s_addr[d][5:0] + i] <= s_wdata[d][8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      s_rdata[d] = (k[d] >= rdl(d) - 1) ?
                   {mem[d][ra[d] + 3], mem[d][ra[d] + 2], mem[d][ra[d] + 1], mem[d][ra[d]]} : junk[d];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] last_rd, last_addr, last_wd;
  logic [7:0]  last_mask;
  logic        last_err;

  task automatic txn(input int d, input logic wen, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wd, input int hold);
    int          n, lat, e0;
    logic        err;
    logic [31:0] exp_rd, exp_wd, held;
    logic [3:0]  exp_m;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((addr % n) != 0);
    exp_rd = 32'h0;
    exp_m = 4'h0;
    exp_wd = 32'h0;
    if (!err && !wen) begin
      for (int i = n - 1; i >= 0; i--) exp_rd = (exp_rd << 8) | 32'(rm[d][addr[5:0] + i]);
      if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
    end
    if (!err && wen) begin
      for (int i = 0; i < n; i++) exp_m[addr[1:0] + i] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
    end
    e0 = ena_cnt[d];

    @(negedge clock);
    rq_wen = wen; rq_addr = addr; rq_size = size; rq_uns = uns; rq_wdata = wd;
    rq_valid[d] = 1'b1;
    #1;
    chk($sformatf("req_ready_idle%0d", d), 32'(req_ready[d]), 32'd1);
    chk($sformatf("sram_ena%0d", d), 32'(s_ena[d]), 32'(!err));
    chk($sformatf("sram_wen%0d", d), 32'(s_wen[d]), 32'(!err && wen));
    chk($sformatf("sram_addr%0d", d), s_addr[d], err ? 32'h0 : {addr[31:2], 2'b00});
    chk($sformatf("sram_wmask%0d", d), 32'(s_wmask[d]), 32'({4'h0, exp_m}));
    if (!err && wen) chk($sformatf("sram_wdata%0d", d), s_wdata[d], exp_wd);
    last_addr = s_addr[d]; last_mask = s_wmask[d]; last_wd = s_wdata[d];

    @(posedge clock); #1;
    rq_valid[d] = 1'b0;
    chk($sformatf("req_ready_busy%0d", d), 32'(req_ready[d]), 32'd0);
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 12) begin
      @(posedge clock); #1;
      lat++;
    end
    chk($sformatf("latency%0d", d), 32'(lat), err ? 32'd0 : 32'(rdl(d)));
    chk($sformatf("resp_err%0d", d), 32'(resp_err[d]), 32'(err));
    chk($sformatf("resp_rdata%0d", d), resp_rdata[d], exp_rd);
    last_rd = resp_rdata[d]; last_err = resp_err[d];
    if (!err && wen) for (int i = 0; i < n; i++) rm[d][addr[5:0] + i] = wd[8*i +: 8];
    held = resp_rdata[d];

    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      chk($sformatf("hold_valid%0d", d), 32'(resp_valid[d]), 32'd1);
      chk($sformatf("hold_rdata%0d", d), resp_rdata[d], held);
      chk($sformatf("hold_ready%0d", d), 32'(req_ready[d]), 32'd0);
    end
    chk($sformatf("ena_count%0d", d), 32'(ena_cnt[d]), 32'(e0 + (err ? 0 : 1)));

    rs_ready[d] = 1'b1;
    @(posedge clock); #1;
    rs_ready[d] = 1'b0;
    chk($sformatf("resp_retired%0d", d), 32'(resp_valid[d]), 32'd0);
    chk($sformatf("req_ready_after%0d", d), 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    rq_valid = '{1'b0, 1'b0};
    rs_ready = '{1'b0, 1'b0};
    rq_wen = 1'b0; rq_uns = 1'b0; rq_addr = 32'h0; rq_wdata = 32'h0; rq_size = 2'd0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) rm[d][i] = (d == 0) ? 8'($urandom) : rm[0][i];
    for (int d = 0; d < 2; d++) begin
      rm[d][0] = 8'h01; rm[d][1] = 8'h7F; rm[d][2] = 8'hFF; rm[d][3] = 8'h80;
      rm[d][4] = 8'hEF; rm[d][5] = 8'hBE; rm[d][6] = 8'hAD; rm[d][7] = 8'hDE;
      for (int i = 0; i < 64; i++) mem[d][i] <= rm[d][i];
    end

    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd0);
      chk($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
      chk($sformatf("rst_resp_rdata%0d", d), resp_rdata[d], 32'h0);
      chk($sformatf("rst_resp_err%0d", d), 32'(resp_err[d]), 32'd0);
      chk($sformatf("rst_sram_ena%0d", d), 32'(s_ena[d]), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    txn(0, 1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 0);
    chk("tp_word_addr", last_addr, 32'h8000_0004);
    chk("tp_word_mask", 32'(last_mask), 32'h0);
    chk("tp_word_rdata", last_rd, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0, 0);
    chk("tp_lb_signed", last_rd, 32'hFFFF_FF80);
    txn(0, 1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0, 0);
    chk("tp_lb_unsigned", last_rd, 32'h0000_0080);
    txn(0, 1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'h0, 0);
    chk("tp_lh_signed", last_rd, 32'hFFFF_80FF);
    txn(0, 1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h1234_ABCD, 0);
    chk("tp_sh_mask", 32'(last_mask), 32'h0000_000C);
    chk("tp_sh_wdata", last_wd, 32'hABCD_ABCD);
    chk("tp_sh_addr", last_addr, 32'h8000_0000);
    chk("tp_sh_rdata", last_rd, 32'h0);
    txn(0, 1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0, 0);
    chk("tp_misaligned_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'h8000_0005, 2'd3, 1'b0, 32'h0, 0);
    chk("tp_reserved_err", 32'(last_err), 32'd1);
    txn(0, 1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 5);
    txn(1, 1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 0);
    chk("tp_lat3_rdata", last_rd, 32'hDEAD_BEEF);

    // Reset while the RD_LAT=3 instance sits in WAIT.
    @(negedge clock);
    rq_wen = 1'b0; rq_addr = 32'h8000_0004; rq_size = 2'd2; rq_uns = 1'b0;
    rq_valid[1] = 1'b1;
    @(posedge clock); #1;
    rq_valid[1] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst_wait_idle", 32'(req_ready[1]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk("rst_wait_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    txn(1, 1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, 0);
    chk("rst_wait_recover", last_rd, 32'hDEAD_BEEF);

    for (int t = 0; t < 300; t++)
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h8000_0000 | 32'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
